// File: rtl/rom_arb_if.sv
// Shared boot-ROM bus: CPU fetch port, DMA/loader port and ROM device pins.
// The arbiter sits on the slave side; requesters and the ROM model sit on the master side.
interface rom_arb_if;
   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 8;

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_strobe;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_strobe;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ce_n;
   logic [DATA_W-1:0] rom_data;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
      output cpu_rdata, cpu_strobe, dma_rdata, dma_strobe, rom_addr, rom_ce_n, busy
   );

   modport master (
      output cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
      input  cpu_rdata, cpu_strobe, dma_rdata, dma_strobe, rom_addr, rom_ce_n, busy
   );
endinterface

// File: rtl/rom_access_arbiter.sv
// Arbitrates CPU and DMA reads onto one ROM chip: fixed CPU priority with a DMA starvation bound,
// fixed-length CE-low access window and one recovery cycle between accesses.
module rom_access_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 3,
   parameter int unsigned DMA_MAX_WAIT = 4
) (
   input logic      fclk,
   input logic      rst_n,
   rom_arb_if.slave bus
);
   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DMA_MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
   typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

   state_t            state, state_nxt;
   owner_t            owner, owner_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_nxt;
   logic [CNT_W-1:0]  starve, starve_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              ce_n_q, ce_n_nxt;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nxt;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_nxt;
   logic              cpu_strobe_q, cpu_strobe_nxt;
   logic              dma_strobe_q, dma_strobe_nxt;
   logic              busy_q, busy_nxt;
   logic              grant_cpu_c, grant_dma_c;

   // Next-state, arbitration and registered-output values
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      wait_nxt       = wait_cnt;
      starve_nxt     = starve;
      addr_nxt       = addr_q;
      ce_n_nxt       = ce_n_q;
      cpu_rdata_nxt  = cpu_rdata_q;
      dma_rdata_nxt  = dma_rdata_q;
      cpu_strobe_nxt = 1'b0;
      dma_strobe_nxt = 1'b0;
      grant_cpu_c    = 1'b0;
      grant_dma_c    = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.dma_req && (starve == STARVE_MAX)) begin
               grant_dma_c = 1'b1;
            end else if (bus.cpu_req) begin
               grant_cpu_c = 1'b1;
            end else if (bus.dma_req) begin
               grant_dma_c = 1'b1;
            end

            if (grant_cpu_c) begin
               owner_nxt = OWN_CPU;
               addr_nxt  = bus.cpu_addr;
               // Consecutive CPU wins only count while DMA is actually waiting
               if (bus.dma_req) begin
                  starve_nxt = (starve < STARVE_MAX) ? starve + CNT_W'(1) : STARVE_MAX;
               end else begin
                  starve_nxt = '0;
               end
            end else if (grant_dma_c) begin
               owner_nxt  = OWN_DMA;
               addr_nxt   = bus.dma_addr;
               starve_nxt = '0;
            end

            if (grant_cpu_c || grant_dma_c) begin
               ce_n_nxt  = 1'b0;
               wait_nxt  = WAIT_INIT;
               state_nxt = ACCESS;
            end
         end

         ACCESS: begin
            if (wait_cnt == '0) begin
               if (owner == OWN_CPU) begin
                  cpu_rdata_nxt  = bus.rom_data;
                  cpu_strobe_nxt = 1'b1;
               end else begin
                  dma_rdata_nxt  = bus.rom_data;
                  dma_strobe_nxt = 1'b1;
               end
               ce_n_nxt  = 1'b1;
               state_nxt = RECOVER;
            end else begin
               wait_nxt = wait_cnt - CNT_W'(1);
            end
         end

         RECOVER: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            ce_n_nxt  = 1'b1;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OWN_CPU;
         wait_cnt     <= '0;
         starve       <= '0;
         addr_q       <= '0;
         ce_n_q       <= 1'b1;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_strobe_q <= 1'b0;
         dma_strobe_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         wait_cnt     <= wait_nxt;
         starve       <= starve_nxt;
         addr_q       <= addr_nxt;
         ce_n_q       <= ce_n_nxt;
         cpu_rdata_q  <= cpu_rdata_nxt;
         dma_rdata_q  <= dma_rdata_nxt;
         cpu_strobe_q <= cpu_strobe_nxt;
         dma_strobe_q <= dma_strobe_nxt;
         busy_q       <= busy_nxt;
      end
   end

   assign bus.rom_addr   = addr_q;
   assign bus.rom_ce_n   = ce_n_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dma_rdata  = dma_rdata_q;
   assign bus.cpu_strobe = cpu_strobe_q;
   assign bus.dma_strobe = dma_strobe_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: table of single accesses plus
// hand-written priority, starvation, back-to-back, reset and address-hold sequences.
module tb_rom_access_arbiter;
   logic fclk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   rom_arb_if bus ();

   rom_access_arbiter #(.WAIT_CYCLES(3), .DMA_MAX_WAIT(4)) dut (
      .fclk (fclk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 fclk = ~fclk;
   always @(posedge fclk) cyc <= cyc + 1;

   // ROM model: data = lo + mid + top + 0x7D (mod 256); 0xEE while deselected
   function automatic logic [7:0] rom_fn(input logic [18:0] a);
      return a[7:0] + a[15:8] + {5'b0, a[18:16]} + 8'h7D;
   endfunction
   assign bus.rom_data = bus.rom_ce_n ? 8'hEE : rom_fn(bus.rom_addr);

   typedef struct {
      int          cyc;
      bit          dma;
      logic [7:0]  data;
      logic [18:0] addr;
   } ev_t;

   ev_t evq[$];
   int  low_runs[$];
   int  high_runs[$];
   int  low_run = 0, high_run = 0, both_cnt = 0, wide_cnt = 0;
   bit  prev_cpu = 0, prev_dma = 0;

   // Monitor: CE run lengths, strobe events, overlapping or stretched strobes
   always @(negedge fclk) begin
      if (bus.rom_ce_n) begin
         if (low_run != 0) low_runs.push_back(low_run);
         low_run = 0;
         high_run++;
      end else begin
         if (high_run != 0) high_runs.push_back(high_run);
         high_run = 0;
         low_run++;
      end
      if (bus.cpu_strobe && bus.dma_strobe) both_cnt++;
      if ((bus.cpu_strobe && prev_cpu) || (bus.dma_strobe && prev_dma)) wide_cnt++;
      prev_cpu = bus.cpu_strobe;
      prev_dma = bus.dma_strobe;
      if (bus.cpu_strobe || bus.dma_strobe)
         evq.push_back('{cyc, bus.dma_strobe,
                         bus.dma_strobe ? bus.dma_rdata : bus.cpu_rdata, bus.rom_addr});
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge fclk);
         #1;
      end
   endtask

   task automatic wait_ev(input int n, input int budget, input string nm);
      int k = 0;
      while (evq.size() < n && k < budget) begin
         step(1);
         k++;
      end
      if (evq.size() < n) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: events=%0d required=%0d", nm, evq.size(), n);
      end
   endtask

   function automatic ev_t ev_at(input int i);
      ev_t e = '{-100, 1'b0, 8'h00, 19'h0};
      if (i < evq.size()) e = evq[i];
      return e;
   endfunction

   typedef struct {
      bit          dma;
      logic [18:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t        vecs[5];
   logic [7:0]  exp_cpu, exp_dma;
   ev_t         e, p;
   int          c0;
   bit [9:0]    order;

   initial begin
      vecs[0] = '{1'b0, 19'h40123, 8'hA5};
      vecs[1] = '{1'b0, 19'h7FFFF, 8'h82};
      vecs[2] = '{1'b1, 19'h00000, 8'h7D};
      vecs[3] = '{1'b1, 19'h12345, 8'hE6};
      vecs[4] = '{1'b0, 19'h00001, 8'h7E};
      exp_cpu = 8'h00;
      exp_dma = 8'h00;

      rst_n        = 1'b0;
      bus.cpu_req  = 1'b0;
      bus.dma_req  = 1'b0;
      bus.cpu_addr = '0;
      bus.dma_addr = '0;
      step(3);
      check("rst_ce_n", 32'(bus.rom_ce_n), 32'd1);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      check("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);
      check("rst_strobes", 32'({bus.cpu_strobe, bus.dma_strobe}), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      step(2);

      // Single accesses from the table
      for (int i = 0; i < 5; i++) begin
         evq.delete();
         low_runs.delete();
         c0 = cyc;
         if (vecs[i].dma) begin
            bus.dma_req = 1'b1; bus.dma_addr = vecs[i].addr;
         end else begin
            bus.cpu_req = 1'b1; bus.cpu_addr = vecs[i].addr;
         end
         wait_ev(1, 20, $sformatf("vec%0d", i));
         bus.cpu_req = 1'b0;
         bus.dma_req = 1'b0;
         e = ev_at(0);
         if (vecs[i].dma) exp_dma = vecs[i].data; else exp_cpu = vecs[i].data;
         check($sformatf("vec%0d_owner", i), 32'(e.dma), 32'(vecs[i].dma));
         check($sformatf("vec%0d_latency", i), 32'(e.cyc - c0), 32'd4);
         check($sformatf("vec%0d_addr", i), 32'(e.addr), 32'(vecs[i].addr));
         check($sformatf("vec%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(exp_cpu));
         check($sformatf("vec%0d_dma_rdata", i), 32'(bus.dma_rdata), 32'(exp_dma));
         check($sformatf("vec%0d_ce_low", i), 32'((low_runs.size() > 0) ? low_runs[0] : 0), 32'd3);
         step(4);
         check($sformatf("vec%0d_events", i), 32'(evq.size()), 32'd1);
         check($sformatf("vec%0d_idle", i), 32'(bus.busy), 32'd0);
      end

      // Simultaneous requests: CPU first, DMA at the next IDLE 5 cycles later
      bus.cpu_addr = 19'h00100;
      bus.dma_addr = 19'h00200;
      evq.delete();
      c0 = cyc;
      bus.cpu_req = 1'b1;
      bus.dma_req = 1'b1;
      wait_ev(1, 20, "simul_cpu");
      bus.cpu_req = 1'b0;
      wait_ev(2, 20, "simul_dma");
      bus.dma_req = 1'b0;
      e = ev_at(0);
      p = ev_at(1);
      check("simul_first_owner", 32'(e.dma), 32'd0);
      check("simul_first_latency", 32'(e.cyc - c0), 32'd4);
      check("simul_second_owner", 32'(p.dma), 32'd1);
      check("simul_spacing", 32'(p.cyc - e.cyc), 32'd5);
      check("simul_dma_data", 32'(p.data), 32'h7F);
      step(4);

      // Both held: four CPU wins then a forced DMA grant (also shows starve restarted at 0)
      evq.delete();
      c0 = cyc;
      bus.cpu_req = 1'b1;
      bus.dma_req = 1'b1;
      wait_ev(10, 80, "held");
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      order = '0;
      for (int i = 0; i < 10; i++) begin
         e = ev_at(i);
         order[i] = e.dma;
         check($sformatf("held%0d_data", i), 32'(e.data), e.dma ? 32'h7F : 32'h7E);
         if (i == 0) check("held0_latency", 32'(e.cyc - c0), 32'd4);
         else begin
            p = ev_at(i - 1);
            check($sformatf("held%0d_spacing", i), 32'(e.cyc - p.cyc), 32'd5);
         end
      end
      check("held_order", 32'(order), 32'(10'b10000_10000));
      step(4);
      exp_cpu = 8'h7E;
      exp_dma = 8'h7F;

      // DMA back-to-back, address advanced after each strobe while req stays high
      evq.delete();
      high_runs.delete();
      bus.dma_addr = 19'h00000;
      bus.dma_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ev(i + 1, 20, $sformatf("b2b%0d", i));
         bus.dma_addr = 19'(i + 1);
      end
      bus.dma_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = ev_at(i);
         check($sformatf("b2b%0d_owner", i), 32'(e.dma), 32'd1);
         check($sformatf("b2b%0d_data", i), 32'(e.data), 32'(8'h7D + 8'(i)));
         if (i > 0) begin
            p = ev_at(i - 1);
            check($sformatf("b2b%0d_spacing", i), 32'(e.cyc - p.cyc), 32'd5);
            check($sformatf("b2b%0d_ce_high", i),
                  32'((high_runs.size() > i) ? high_runs[i] : 0), 32'd2);
         end
      end
      check("b2b_cpu_rdata_kept", 32'(bus.cpu_rdata), 32'(exp_cpu));
      step(4);

      // Reset asserted in the second ACCESS cycle
      evq.delete();
      bus.cpu_addr = 19'h12345;
      bus.cpu_req  = 1'b1;
      step(2);
      check("rstmid_busy_before", 32'(bus.busy), 32'd1);
      check("rstmid_ce_before", 32'(bus.rom_ce_n), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rstmid_ce_n", 32'(bus.rom_ce_n), 32'd1);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      check("rstmid_dma_rdata", 32'(bus.dma_rdata), 32'd0);
      step(2);
      check("rstmid_no_strobe", 32'(evq.size()), 32'd0);
      c0 = cyc;
      rst_n = 1'b1;
      step(1);
      check("rstmid_regrant_ce", 32'(bus.rom_ce_n), 32'd0);
      check("rstmid_regrant_addr", 32'(bus.rom_addr), 32'h12345);
      wait_ev(1, 20, "rstmid_access");
      bus.cpu_req = 1'b0;
      e = ev_at(0);
      check("rstmid_latency", 32'(e.cyc - c0), 32'd4);
      check("rstmid_data", 32'(e.data), 32'hE6);
      check("rstmid_dma_rdata_kept", 32'(bus.dma_rdata), 32'd0);
      step(4);

      // Address changed mid-ACCESS must not reach the ROM pins
      evq.delete();
      c0 = cyc;
      bus.cpu_addr = 19'h2A5A5;
      bus.cpu_req  = 1'b1;
      step(2);
      check("hold_addr_granted", 32'(bus.rom_addr), 32'h2A5A5);
      bus.cpu_addr = 19'h10000;
      wait_ev(1, 20, "hold_access");
      bus.cpu_req = 1'b0;
      e = ev_at(0);
      check("hold_addr_at_strobe", 32'(e.addr), 32'h2A5A5);
      check("hold_data", 32'(e.data), 32'hC9);
      check("hold_latency", 32'(e.cyc - c0), 32'd4);
      step(4);

      check("never_both_strobes", 32'(both_cnt), 32'd0);
      check("strobe_one_cycle", 32'(wide_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single 512 KB boot/ROM chip (19-bit address, 8-bit data, active-low CE) between two requesters: the Z80 ROM fetch path (CPU) and a background DMA/loader port.
- Sequences every ROM read: drives address and CE, waits a fixed access time, captures data, then enforces one recovery cycle.
- Arbitration is fixed priority to CPU, with a starvation bound that forces a DMA grant after a set number of consecutive CPU wins.
- Sits between the memory-mapping logic and the ROM device pins.

Parameters:
- WAIT_CYCLES, 3, number of cycles rom_ce_n is low before data is sampled. Legal range 1..15.
- DMA_MAX_WAIT, 4, number of consecutive CPU grants allowed while dma_req is pending before DMA is forced. Legal range 1..15.

Ports:
- fclk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU read request, level; held until cpu_strobe
- cpu_addr  input  19  CPU ROM address, stable while cpu_req high
- cpu_rdata  output  8  CPU read data, valid from cpu_strobe until next cpu_strobe
- cpu_strobe  output  1  one-cycle pulse, CPU access complete
- dma_req  input  1  DMA read request, same rules as cpu_req
- dma_addr  input  19  DMA ROM address
- dma_rdata  output  8  DMA read data
- dma_strobe  output  1  one-cycle pulse, DMA access complete
- rom_addr  output  19  ROM address pins, registered
- rom_ce_n  output  1  ROM chip enable, active low, registered
- rom_data  input  8  ROM data pins; undefined while rom_ce_n high
- busy  output  1  high when state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rom_ce_n=1, rom_addr=0, cpu_rdata=dma_rdata=0, both strobes 0, busy=0.
  - Internal: state=IDLE, wait counter=0, starve counter=0, owner=CPU.
  - Reset mid-access aborts the access with no strobe. First arbitration happens on the first edge after release.
- States: IDLE, ACCESS, RECOVER.
- IDLE arbitration at edge E0:
  - If dma_req and starve==DMA_MAX_WAIT, DMA wins.
  - Else if cpu_req, CPU wins.
  - Else if dma_req, DMA wins.
  - Else stay in IDLE.
- On a grant at E0:
  - rom_addr is set to the winner's address, rom_ce_n=0, owner is latched, wait counter=WAIT_CYCLES-1, next state ACCESS.
- Starve counter update at grant:
  - CPU grant while dma_req high: starve increments, saturating at DMA_MAX_WAIT.
  - DMA grant: starve clears to 0.
  - CPU grant with dma_req low: starve clears to 0.
- ACCESS:
  - Each edge decrements the wait counter.
  - At the edge where the counter is 0 (edge E0+WAIT_CYCLES):
    - rom_data is captured into the owner's rdata.
    - The owner's strobe goes to 1 for exactly one cycle.
    - rom_ce_n goes to 1 and next state is RECOVER.
  - rom_addr holds its value through ACCESS and RECOVER.
- RECOVER: one cycle; strobe returns to 0; next state IDLE.
- Timing:
  - rom_ce_n is low for exactly WAIT_CYCLES cycles.
  - rom_ce_n is high for at least 1 cycle between accesses.
  - Minimum access period is WAIT_CYCLES+2 cycles.
- Handshake:
  - A requester deasserts req on the edge after observing its strobe.
  - If req is still high at the next IDLE edge, it is treated as a new request at the current address.
  - Addresses are sampled only at the grant edge. Changes during ACCESS have no effect.
- Requests arriving during ACCESS or RECOVER wait; nothing is lost, since req is a level.
- Never both strobes in one cycle. The non-owner's rdata is unchanged by an access.
- busy = (state != IDLE), registered with the state.

Test Plan:
- CPU alone, WAIT_CYCLES=3, cpu_addr=0x4_0123, ROM model returns 0xA5 → rom_ce_n low 3 cycles, cpu_strobe 1 cycle at E0+3, cpu_rdata=0xA5, dma_strobe never asserted.
- cpu_req and dma_req rise in the same cycle, starve=0 → CPU granted first; DMA granted at the next IDLE, 5 cycles later; starve ends at 0.
- Both requests held high continuously, DMA_MAX_WAIT=4 → grant order C,C,C,C,D,C,C,C,C,D; each strobe spaced 5 cycles apart.
- DMA alone, back-to-back, addresses 0x00000..0x00003 → four dma_strobe pulses 5 cycles apart; rom_ce_n high exactly 2 cycles between accesses (RECOVER+IDLE); data matches ROM model.
- rst_n pulsed low during ACCESS cycle 2 → rom_ce_n=1 immediately (async), no strobe, both rdata=0; a pending cpu_req is granted on the first edge after release.
- cpu_addr changed mid-ACCESS → rom_addr keeps the granted value; captured data corresponds to the original address.
